seq_mult: RTL and testbench
===========================

SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand width in bits.
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width; SHALL satisfy 2^CNT_W > XLEN.
REQ-003 SHALL have input clk, 1 bit, system clock; all state updates on its rising edge.
REQ-004 SHALL have input rst, 1 bit, reset: asynchronous, active-high.
REQ-005 SHALL have input start, 1 bit, request to begin a multiply with the current operands.
REQ-006 SHALL have input a, XLEN bits, unsigned multiplicand.
REQ-007 SHALL have input b, XLEN bits, unsigned multiplier.
REQ-008 SHALL have output busy, 1 bit, high while an iteration sequence is running.
REQ-009 SHALL have output done, 1 bit, single-cycle pulse marking product valid; intended as load enable for the downstream result registers.
REQ-010 SHALL have output prod_hi, XLEN bits, upper half of the 2*XLEN product.
REQ-011 SHALL have output prod_lo, XLEN bits, lower half of the 2*XLEN product.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at an edge SHALL capture a into the multiplicand register, b into prod_lo, clear prod_hi, clear the counter, and enter RUN.
REQ-014 RUN: each edge SHALL perform one shift-add step: if prod_lo[0]=1, add the multiplicand to prod_hi with an XLEN+1-bit sum; then shift {carry, prod_hi, prod_lo} right by one.
REQ-015 RUN SHALL last exactly XLEN edges; on the XLEN-th step edge the FSM SHALL enter DONE.
REQ-016 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+XLEN (33 edges for XLEN=32).
REQ-017 DONE SHALL last one cycle and then return to IDLE unless start=1 (see REQ-020).
REQ-018 busy SHALL be high exactly in RUN; done SHALL be high exactly in DONE; both SHALL be registered state decodes.
REQ-019 start SHALL be ignored in RUN; the operands and sequence SHALL be unaffected.
REQ-020 start=1 in DONE SHALL be accepted as in REQ-013 (back-to-back), entering RUN with no IDLE cycle.
REQ-021 prod_hi/prod_lo SHALL hold the final product from DONE onward until the next accepted start.
REQ-022 Arithmetic SHALL be unsigned modulo 2^(2*XLEN); the result SHALL never overflow because the full product fits.
REQ-023 a and b SHALL be sampled only at the accepting edge; later changes SHALL NOT affect the running product.
REQ-024 An illegal state encoding SHALL return to IDLE at the next edge.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, prod_hi=0, prod_lo=0, counter=0, multiplicand=0, independent of clk.
REQ-026 rst asserted mid-RUN SHALL abort the sequence; no done pulse SHALL follow for the aborted operation.
REQ-027 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Structure
REQ-028 The shared package SHALL hold XLEN, the FSM state encoding (IDLE, RUN, DONE), and the default CNT_W.
REQ-029 The XLEN+1-bit adder SHALL be a separate sub-module, add_cout, with inputs x and y and output {cout, sum}.
REQ-030 No other sub-modules SHALL be instantiated; downstream result latching SHALL remain outside this block.

Verification
REQ-031 a=3, b=5, start pulse -> busy high for 32 cycles; done then pulses once; prod_hi=0x00000000, prod_lo=0x0000000F.
REQ-032 a=0xFFFFFFFF, b=0xFFFFFFFF -> prod_hi=0xFFFFFFFE, prod_lo=0x00000001 when done is high.
REQ-033 a=0x12345678, b=0 -> product 0; then start held high during RUN with a=7, b=7 -> result still 0; no extra done pulse.
REQ-034 Back-to-back: start high during DONE with a=2, b=0x80000000 -> busy the next cycle; second done gives prod_hi=0x00000001, prod_lo=0x00000000.
REQ-035 rst pulsed at RUN step 10 of a=9, b=9 -> all outputs 0 immediately; no done pulse; a new start of 9x9 yields prod_lo=0x51.
REQ-036 Randomised 1000 operand pairs against a 64-bit reference model -> exact match at every done; done count equals accepted-start count.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   XLEN    : default operand width in bits
//   CNT_W   : default iteration counter width (2**CNT_W must exceed XLEN)
//   state_t : FSM state encoding (IDLE, RUN, DONE)
package seq_mult_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_mult_add_cout.sv
// Unsigned W-bit adder that also returns the carry out, so the result is
// the full W+1-bit sum.
//   x, y : W-bit unsigned addends
//   cout : carry out (bit W of the sum)
//   sum  : low W bits of the sum
module add_cout #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         cout,
  output logic [W-1:0] sum
);

  assign {cout, sum} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/seq_mult.sv
// Sequential unsigned multiplier using the shift-add algorithm, one
// multiplier bit per clock. The multiplier is loaded into prod_lo and
// shifted out as the product shifts in, so the 2*XLEN product ends up in
// {prod_hi, prod_lo} after XLEN steps.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   start   : begin a multiply with a/b (accepted in IDLE or DONE only)
//   a, b    : unsigned multiplicand / multiplier, sampled on the accepting edge
//   busy    : high while the step sequence runs
//   done    : one-cycle pulse, product valid (load enable for downstream regs)
//   prod_hi : upper half of the product
//   prod_lo : lower half of the product
// CNT_W must satisfy 2**CNT_W > XLEN so the counter can reach XLEN.
module seq_mult #(
  parameter int XLEN  = seq_mult_pkg::XLEN,
  parameter int CNT_W = seq_mult_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] prod_hi,
  output logic [XLEN-1:0] prod_lo
);

  // Explicit imports: a wildcard import would collide with the XLEN/CNT_W
  // parameter names declared above.
  import seq_mult_pkg::state_t;
  import seq_mult_pkg::IDLE;
  import seq_mult_pkg::RUN;
  import seq_mult_pkg::DONE;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   mcand;
  logic              accept;
  logic              last_step;
  logic [XLEN-1:0]   add_y;
  logic [XLEN-1:0]   sum;
  logic              cout;

  // A start is honoured only when no sequence is running; in DONE this
  // gives back-to-back operation without an IDLE bubble.
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_step = (cnt == CNT_W'(XLEN - 1));

  // Add the multiplicand only when the current multiplier bit is set.
  assign add_y = prod_lo[0] ? mcand : '0;

  add_cout #(
    .W (XLEN)
  ) u_add (
    .x    (prod_hi),
    .y    (add_y),
    .cout (cout),
    .sum  (sum)
  );

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned; otherwise a latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;  // recover from the unused encoding
    endcase
  end

  // Datapath: load on accept, one shift-add step per RUN cycle, hold
  // otherwise so the product stays visible after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
      cnt     <= '0;
    end else if (accept) begin
      mcand   <= a;
      prod_hi <= '0;
      prod_lo <= b;
      cnt     <= '0;
    end else if (state == RUN) begin
      // Shift {cout, sum, prod_lo} right by one: the carry becomes the new
      // MSB and the consumed multiplier bit falls off the bottom.
      prod_hi <= {cout, sum[XLEN-1:1]};
      prod_lo <= {sum[0], prod_lo[XLEN-1:1]};
      cnt     <= cnt + 1'b1;
    end
  end

  // Pure decodes of the state register, so both are glitch-free flop outputs
  // of the encoding and fall to 0 in the unused encoding.
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: directed vectors with hand-computed
// products plus random operands against a 64-bit reference. Stimulus pushes
// expected products into a queue; an independent monitor pops and compares
// on every done pulse.
module tb_seq_mult;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            start;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] prod_hi;
  logic [XLEN-1:0] prod_lo;

  logic [63:0] exp_q[$];
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          n_accept  = 0;
  int          n_done    = 0;

  seq_mult #(
    .XLEN  (XLEN),
    .CNT_W (6)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .prod_hi (prod_hi),
    .prod_lo (prod_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with product 0x%0h, expected no done",
                 {prod_hi, prod_lo});
      end else begin
        check("product", {prod_hi, prod_lo}, exp_q.pop_front());
      end
    end
  end

  // Present a start for one edge; operands are scrambled right after the
  // accepting edge so any late sampling of a/b corrupts the product.
  task automatic issue(input logic [XLEN-1:0] av, input logic [XLEN-1:0] bv,
                       input logic [63:0] exp);
    a     = av;
    b     = bv;
    start = 1'b1;
    exp_q.push_back(exp);
    n_accept++;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~av;
    b     = bv ^ 32'h5A5A_A5A5;
  endtask

  // Wait (bounded) for done; returns the number of busy cycles seen first.
  // Returns at the negedge where done is observed.
  task automatic wait_done(input string name, output int busy_cycles);
    bit seen;
    seen        = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) busy_cycles++;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  initial begin
    int          bc;
    int          done_before;
    logic [31:0] ra;
    logic [31:0] rb;

    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1 rst = 1'b1;
    #2;
    check("reset_outputs", {busy, done, prod_hi, prod_lo}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 3 x 5: 32 busy cycles, then a single done, product held afterwards.
    issue(32'd3, 32'd5, 64'h0000_0000_0000_000F);
    wait_done("done_3x5", bc);
    check("busy_cycles_3x5", 64'(bc), 64'd32);
    @(negedge clk);
    check("done_one_cycle", {62'd0, done, busy}, 64'd0);
    check("product_held", {prod_hi, prod_lo}, 64'h0000_0000_0000_000F);

    // All-ones squared: exercises the carry out on every step.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_done("done_max", bc);
    @(negedge clk);

    // Zero multiplier, with start held during RUN using other operands.
    done_before = n_done;
    issue(32'h1234_5678, 32'd0, 64'd0);
    start = 1'b1;
    a     = 32'd7;
    b     = 32'd7;
    repeat (10) @(posedge clk);
    #1 start = 1'b0;
    wait_done("done_zero", bc);
    repeat (5) @(negedge clk);
    check("no_extra_done", 64'(n_done - done_before), 64'd1);

    // Back-to-back: new start accepted in the DONE cycle.
    issue(32'd5, 32'd6, 64'd30);
    wait_done("done_5x6", bc);
    issue(32'd2, 32'h8000_0000, 64'h0000_0001_0000_0000);
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done("done_b2b", bc);
    check("busy_cycles_b2b", 64'(bc), 64'd32);
    @(negedge clk);

    // Reset mid-RUN aborts without a done; outputs clear without a clock.
    done_before = n_done;
    a     = 32'd9;
    b     = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_reset", {busy, done, prod_hi, prod_lo}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", 64'(n_done - done_before), 64'd0);
    issue(32'd9, 32'd9, 64'h51);
    wait_done("done_9x9", bc);
    check("busy_cycles_9x9", 64'(bc), 64'd32);

    // Random operands against the 64-bit reference product.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      issue(ra, rb, {32'd0, ra} * {32'd0, rb});
      wait_done("done_rand", bc);
    end

    repeat (3) @(negedge clk);
    check("done_count", 64'(n_done), 64'(n_accept));
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
